// File: rtl/sad_accum_select.sv
// Sums 25 quarter-pel candidate diff rows over one block into SADs, then scans
// them one per cycle and reports the minimum as a motion-vector refinement.
module sad_accum_select #(
  parameter int ROWS  = 6,
  parameter int SAD_W = 14
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1199:0]    diff_bus,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SAD_W-1:0] best_sad,
  output logic [4:0]       best_idx,
  output logic [2:0]       best_mvx,
  output logic [2:0]       best_mvy,
  output logic [1:0]       dbg_state
);

  // Handshakes: a transfer happens on a rising edge with valid & ready both
  // high; valid holds its payload stable until then, ready never looks at valid.

  localparam int NCAND  = 25;
  localparam int CENTRE = 12;

  if (ROWS < 1 || ROWS > 6) begin : g_bad_rows
    $error("sad_accum_select: ROWS must be in 1..6");
  end
  if ((64'd1 << SAD_W) <= 64'(ROWS) * 64'd1530) begin : g_bad_sad_w
    $error("sad_accum_select: SAD_W too narrow for ROWS*1530");
  end

  typedef enum logic [1:0] {
    S_ACC  = 2'd0,
    S_CMP  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic             r_in_ready;
  logic [2:0]       r_row;
  logic [SAD_W-1:0] r_acc [NCAND];
  logic [10:0]      w_row_sum [NCAND];
  logic [4:0]       r_idx;
  logic [SAD_W-1:0] r_best;
  logic [4:0]       r_best_idx;
  logic [SAD_W-1:0] w_cand;
  logic             w_accept;
  logic             w_last_row;
  logic             w_cmp_last;
  logic             w_release;
  logic [2:0]       w_best_v;
  logic [2:0]       w_best_h;
  logic             r_out_valid;
  logic [SAD_W-1:0] r_out_sad;
  logic [4:0]       r_out_idx;
  logic [2:0]       r_out_mvx;
  logic [2:0]       r_out_mvy;

  assign w_accept   = in_valid & r_in_ready;
  assign w_last_row = w_accept & (r_row == 3'(ROWS - 1));
  assign w_cmp_last = (r_state == S_CMP) & (r_idx == 5'd25);
  assign w_release  = (r_state == S_DONE) & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_ACC;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_ACC:   if (w_last_row) w_next_state = S_CMP;
      S_CMP:   if (w_cmp_last) w_next_state = S_DONE;
      S_DONE:  if (out_ready)  w_next_state = S_ACC;
      default: w_next_state = S_ACC;
    endcase
  end

  // Registered so it stays low through reset and never follows in_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_in_ready <= 1'b0;
    end else begin
      r_in_ready <= (w_next_state == S_ACC);
    end
  end

  always_comb begin
    for (int k = 0; k < NCAND; k++) begin
      w_row_sum[k] = '0;
      for (int j = 0; j < 6; j++) begin
        w_row_sum[k] = w_row_sum[k] + 11'(diff_bus[48*k + 8*j +: 8]);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_row <= '0;
    end else if (w_last_row || w_release) begin
      r_row <= '0;
    end else if (w_accept) begin
      r_row <= r_row + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NCAND; k++) r_acc[k] <= '0;
    end else if (w_accept) begin
      for (int k = 0; k < NCAND; k++) r_acc[k] <= r_acc[k] + SAD_W'(w_row_sum[k]);
    end else if (w_release) begin
      for (int k = 0; k < NCAND; k++) r_acc[k] <= '0;
    end
  end

  always_comb begin
    w_cand = '0;
    if (r_idx < 5'd25) w_cand = r_acc[r_idx];
  end

  // Seeding with the centre and replacing only on a strict win gives the
  // centre every tie, and otherwise the lowest index among equal minima.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx      <= '0;
      r_best     <= '0;
      r_best_idx <= '0;
    end else if (w_last_row) begin
      r_idx      <= '0;
      r_best     <= r_acc[CENTRE] + SAD_W'(w_row_sum[CENTRE]);
      r_best_idx <= 5'(CENTRE);
    end else if (r_state == S_CMP && r_idx < 5'd25) begin
      if (w_cand < r_best) begin
        r_best     <= w_cand;
        r_best_idx <= r_idx;
      end
      r_idx <= r_idx + 5'd1;
    end
  end

  assign w_best_v = 3'(r_best_idx / 5'd5);
  assign w_best_h = 3'(r_best_idx % 5'd5);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_sad   <= '0;
      r_out_idx   <= '0;
      r_out_mvx   <= '0;
      r_out_mvy   <= '0;
    end else if (w_cmp_last) begin
      r_out_valid <= 1'b1;
      r_out_sad   <= r_best;
      r_out_idx   <= r_best_idx;
      r_out_mvx   <= w_best_h - 3'd2;
      r_out_mvy   <= w_best_v - 3'd2;
    end else if (w_release) begin
      r_out_valid <= 1'b0;
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign best_sad  = r_out_sad;
  assign best_idx  = r_out_idx;
  assign best_mvx  = r_out_mvx;
  assign best_mvy  = r_out_mvy;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_sad_accum_select.sv
// Bench for sad_accum_select: table vectors, backpressure, reset and gap
// sequences, and random blocks scored against an argmin model.
module tb_sad_accum_select;

  localparam int SAD_W = 14;
  localparam int EW    = 25;

  typedef struct packed {
    int base;
    int k0; int v0;
    int k1; int v1;
    int k2; int v2;
    int e_sad; int e_idx; int e_mvx; int e_mvy;
  } vec_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [1199:0]    diff_bus;
  logic             out_valid;
  logic             out_ready;
  logic [SAD_W-1:0] best_sad;
  logic [4:0]       best_idx;
  logic [2:0]       best_mvx;
  logic [2:0]       best_mvy;
  logic [1:0]       dbg_state;

  int               n_cmp  = 0;
  int               n_fail = 0;
  int               cyc    = 0;
  int               t_last = 0;
  logic [EW-1:0]    exp_q[$];
  logic [1199:0]    cur_blk [6];
  vec_t             vecs [6];

  sad_accum_select #(.ROWS(6), .SAD_W(SAD_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .diff_bus  (diff_bus),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .best_sad  (best_sad),
    .best_idx  (best_idx),
    .best_mvx  (best_mvx),
    .best_mvy  (best_mvy),
    .dbg_state (dbg_state)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [1199:0] rand_bus();
    logic [1215:0] tmp;
    for (int i = 0; i < 38; i++) tmp[32*i +: 32] = $urandom;
    return tmp[1199:0];
  endfunction

  function automatic logic [EW-1:0] pack_exp(input int sad, input int idx, input int mvx, input int mvy);
    return {14'(sad), 5'(idx), 3'(mvx), 3'(mvy)};
  endfunction

  // reference: plain sums, global minimum, centre preferred, else first index
  function automatic logic [EW-1:0] model_result();
    int sad [25];
    int mn;
    int bk;
    for (int k = 0; k < 25; k++) begin
      sad[k] = 0;
      for (int r = 0; r < 6; r++)
        for (int j = 0; j < 6; j++)
          sad[k] += int'(cur_blk[r][48*k + 8*j +: 8]);
    end
    mn = sad[0];
    for (int k = 1; k < 25; k++) if (sad[k] < mn) mn = sad[k];
    if (sad[12] == mn) bk = 12;
    else begin
      bk = -1;
      for (int k = 0; k < 25; k++) if (bk < 0 && sad[k] == mn) bk = k;
    end
    return pack_exp(mn, bk, bk % 5 - 2, bk / 5 - 2);
  endfunction

  task automatic fill_vec(input vec_t v);
    int val;
    for (int r = 0; r < 6; r++)
      for (int k = 0; k < 25; k++) begin
        val = v.base;
        if (k == v.k0) val = v.v0;
        if (k == v.k1) val = v.v1;
        if (k == v.k2) val = v.v2;
        for (int j = 0; j < 6; j++) cur_blk[r][48*k + 8*j +: 8] = 8'(val);
      end
  endtask

  task automatic fill_random(input int maxv);
    for (int r = 0; r < 6; r++)
      for (int b = 0; b < 150; b++)
        cur_blk[r][8*b +: 8] = 8'($urandom_range(maxv, 0));
  endtask

  // driver: starts and ends at a negedge
  task automatic send_row(input logic [1199:0] row, input int gap_max);
    int gaps;
    int t;
    gaps = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
    repeat (gaps) begin
      in_valid = 1'b0;
      diff_bus = rand_bus();
      @(negedge clk);
    end
    in_valid = 1'b1;
    diff_bus = row;
    t = 0;
    while (!in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      n_cmp++;
      n_fail++;
      $display("FAIL row_accept_timeout: in_ready=%0d required 1", in_ready);
    end
    @(posedge clk);
    @(negedge clk);
    t_last   = cyc;
    in_valid = 1'b0;
    diff_bus = rand_bus();
  endtask

  task automatic send_block(input int gap_max, input int nrows);
    for (int r = 0; r < nrows; r++) send_row(cur_blk[r], gap_max);
  endtask

  // scoreboard side: wait, compare, optionally stall, then release
  task automatic wait_result(input int bp_cycles);
    logic [EW-1:0] e;
    int t;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL scoreboard_empty: queue size 0 required >0");
      return;
    end
    e = exp_q.pop_front();
    t = 0;
    while (!out_valid && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!out_valid) begin
      n_cmp++;
      n_fail++;
      $display("FAIL result_timeout: out_valid=%0d required 1", out_valid);
      return;
    end
    check("latency", cyc - t_last, 26);
    check("best_sad", best_sad, 32'(e[24:11]));
    check("best_idx", best_idx, 32'(e[10:6]));
    check("best_mvx", best_mvx, 32'(e[5:3]));
    check("best_mvy", best_mvy, 32'(e[2:0]));
    check("done_in_ready", in_ready, 0);
    repeat (bp_cycles) begin
      in_valid = 1'($urandom_range(1, 0));
      diff_bus = rand_bus();
      @(negedge clk);
      check("bp_out_valid", out_valid, 1);
      check("bp_in_ready", in_ready, 0);
      check("bp_sad", best_sad, 32'(e[24:11]));
      check("bp_idx", best_idx, 32'(e[10:6]));
      check("bp_mv", {best_mvx, best_mvy}, 32'(e[5:0]));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("release_out_valid", out_valid, 0);
    @(negedge clk);
    check("release_in_ready", in_ready, 1);
  endtask

  initial begin
    logic [EW-1:0] e;
    vecs[0] = '{0,  -1, 0, -1, 0, -1, 0, 0,    12, 0,  0};
    vecs[1] = '{10,  7, 3, -1, 0, -1, 0, 108,  7,  0,  -1};
    vecs[2] = '{10, 24, 1, -1, 0, -1, 0, 36,   24, 2,  2};
    vecs[3] = '{9,   3, 5, 12, 5, 20, 5, 180,  12, 0,  0};
    vecs[4] = '{9,   3, 4, 20, 4, 12, 5, 144,  3,  1,  -2};
    vecs[5] = '{255, -1, 0, -1, 0, -1, 0, 9180, 12, 0,  0};

    rst_n     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    diff_bus  = '0;
    #1 rst_n  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_best_sad", best_sad, 0);
    check("rst_best_idx", best_idx, 0);
    check("rst_best_mv", {best_mvx, best_mvy}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);

    // table vectors; vector 4 also held under backpressure for 10 cycles
    for (int i = 0; i < 6; i++) begin
      fill_vec(vecs[i]);
      exp_q.push_back(pack_exp(vecs[i].e_sad, vecs[i].e_idx, vecs[i].e_mvx, vecs[i].e_mvy));
      send_block(0, 6);
      wait_result((i == 4) ? 10 : 0);
    end

    // reset after 3 accepted rows discards the partial block
    fill_random(255);
    send_block(0, 3);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_best_sad", best_sad, 0);
    check("midrst_best_idx", best_idx, 0);
    check("midrst_best_mv", {best_mvx, best_mvy}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_in_ready", in_ready, 1);
    fill_random(255);
    exp_q.push_back(model_result());
    send_block(2, 6);
    wait_result(0);

    // same block back-to-back and with gaps must agree with one model value
    fill_random(3);
    e = model_result();
    exp_q.push_back(e);
    send_block(0, 6);
    wait_result(0);
    exp_q.push_back(e);
    send_block(4, 6);
    wait_result(0);

    for (int n = 0; n < 8; n++) begin
      fill_random((n % 2 == 0) ? 2 : 255);
      exp_q.push_back(model_result());
      send_block(int'($urandom_range(3, 0)), 6);
      wait_result(int'($urandom_range(2, 0)));
    end

    check("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/sad_accum_select.md
Name: sad_accum_select

Overview:
- Consumer of one abs_diff_line output row per cycle.
- Accumulates the 25 fractional-position absolute-difference rows (5 vertical × 5 horizontal, 6 pixels each) over the 6 rows of the inner 6x6 block into 25 SADs.
- Sequentially selects the minimum-SAD candidate and reports it as a quarter-pel motion-vector refinement to the motion-estimation controller.

Parameters:
- ROWS, 6, rows accumulated per block; legal range 1..6.
- SAD_W, 14, accumulator width; 6*6*255 = 9180 fits, so no saturation is needed.

Ports:
- clk  input  1  system clock; all registers rise-edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  diff_bus carries one valid row.
- in_ready  output  1  block accepts a row this cycle.
- diff_bus  input  1200  25 packed 48-bit diff rows. Candidate k occupies [48k+47:48k]. k = 5*v + h, where v = UH,UQ,M,LQ,LH = 0..4 and h = h,q,f,r,i = 0..4. Byte j of each row is pixel j.
- out_valid  output  1  result valid; held until accepted.
- out_ready  input  1  downstream accepts the result.
- best_sad  output  SAD_W  minimum SAD.
- best_idx  output  5  winning k, 0..24.
- best_mvx  output  3  signed quarter-pel x offset = h-2.
- best_mvy  output  3  signed quarter-pel y offset = v-2.

Behaviour:
- Reset (async, rst_n=0):
  - State ACC; row counter 0; all 25 accumulators 0.
  - out_valid=0, best_sad=0, best_idx=0, best_mvx=0, best_mvy=0.
  - in_ready=1 from the first clock after release.
- Reset mid-block discards all partial sums; the next accepted row is row 0 of a new block.
- State ACC:
  - in_ready=1. A row is accepted on in_valid & in_ready.
  - On accept: acc[k] <= acc[k] + sum of the 6 bytes of row k, for all k in parallel, in one cycle. Byte sums are zero-extended; per-row sum is at most 1530.
  - in_valid gaps are allowed; the row counter advances only on accept.
  - When the accepted row is row ROWS-1, go to CMP next cycle, with idx=0, best=acc[12] (updated), best_idx=12.
- State CMP:
  - in_ready=0; in_valid and diff_bus are ignored.
  - One candidate per cycle, idx 0..24: if acc[idx] < best (strict) then best <= acc[idx], best_idx <= idx.
  - Tie rule: the centre (k=12, full-pel) wins all ties. Otherwise the lowest index among equal minima wins.
  - After idx=24 is evaluated, go to DONE.
  - Latency: last row accepted at edge T; CMP occupies T+1..T+25; out_valid=1 after edge T+26.
- State DONE:
  - out_valid=1.
  - best_sad, best_idx, best_mvx, best_mvy are registered and stable while out_valid & !out_ready.
  - in_ready=0.
  - On out_valid & out_ready: out_valid <= 0, all accumulators and the row counter cleared, return to ACC. in_ready rises the following cycle; there is no same-cycle row accept.
- Output fields are updated only on the transition into DONE and retain their values afterwards until the next result.
- best_mvx and best_mvy are sign-extended 3-bit two's complement in the range -2..+2.
- No overflow is possible at the defaults. For other parameters, SAD_W must satisfy 2^SAD_W > ROWS*1530; this is enforced by a static elaboration check.

Test Plan:
- All diff bytes 0, 6 rows -> out_valid at T+26; best_sad=0, best_idx=12, mvx=0, mvy=0.
- All bytes 10, except candidate 7 (UQ_f) bytes 3 -> best_sad=108, best_idx=7, mvx=0, mvy=-1. Repeat with candidate 24 bytes 1 -> best_sad=36, idx=24, mvx=+2, mvy=+2.
- Ties:
  - Candidates 3, 12 and 20 at 5, others at 9 -> idx=12, sad=180.
  - Candidates 3 and 20 at 4, 12 at 5 -> idx=3 (mvx=+1, mvy=-2), sad=144.
- All bytes 255 -> best_sad=9180, idx=12, no wrap.
- Backpressure:
  - Hold out_ready=0 for 10 cycles -> outputs stable, in_ready=0, in_valid pulses ignored.
  - Then raise out_ready -> out_valid drops next edge, in_ready=1 one cycle later.
  - The next block is computed from fresh zeroed sums.
- Reset and gaps:
  - rst_n pulsed low after 3 accepted rows -> outputs zero immediately; a following 6-row block gives the correct result.
  - Random in_valid gaps -> identical result to back-to-back rows.
